// File: rtl/pixel_line_writer.sv
// Writes captured pixels into a ring of RAM line slots and
// signals each complete line to the output side.
module pixel_line_writer #(
  parameter int LINE_WIDTH = 720,
  parameter int RING_LINES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        line_doubler,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  input  logic [11:0] counterX,
  input  logic [11:0] counterY,
  input  logic        add_line,
  input  logic        is_pal,
  input  logic        resync,
  input  logic        line_consumed,
  output logic [11:0] ram_wraddress,
  output logic [23:0] ram_wrdata,
  output logic        ram_wren,
  output logic        line_ready,
  output logic [11:0] line_number,
  output logic [2:0]  lines_pending,
  output logic        overflow,
  output logic        active
);

  localparam int SW = (RING_LINES > 1) ? $clog2(RING_LINES) : 1;
  localparam logic [11:0] LW = 12'(LINE_WIDTH);
  localparam logic [11:0] LAST_X = 12'(LINE_WIDTH - 1);
  localparam logic [2:0] FULL = 3'(RING_LINES);

  typedef enum logic {
    SYNC_WAIT,
    CAPTURE
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] xprev_q, xprev_d;
  logic        stable_q, stable_d;
  logic        drop_q, drop_d;
  logic        ovf_q, ovf_d;
  logic [2:0]  pend_q, pend_d;
  logic        wren_q, wren_d;
  logic [11:0] addr_q, addr_d;
  logic [23:0] data_q, data_d;
  logic        lr_q, lr_d;
  logic [11:0] lnum_q, lnum_d;

  logic        same_x;
  logic        pix_ev;
  logic        in_view;
  logic        enter;
  logic        cap;
  logic        line_start;
  logic        full;
  logic        wr;
  logic [11:0] vis_h;
  logic [11:0] row_base;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= SYNC_WAIT;
      xprev_q  <= 12'hFFF;
      stable_q <= 1'b0;
      drop_q   <= 1'b0;
      ovf_q    <= 1'b0;
      pend_q   <= 3'd0;
      wren_q   <= 1'b0;
      addr_q   <= 12'd0;
      data_q   <= 24'd0;
      lr_q     <= 1'b0;
      lnum_q   <= 12'd0;
    end else begin
      state_q  <= state_d;
      xprev_q  <= xprev_d;
      stable_q <= stable_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      pend_q   <= pend_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      lr_q     <= lr_d;
      lnum_q   <= lnum_d;
    end
  end

  always_comb begin
    same_x   = (counterX == xprev_q);
    pix_ev   = same_x && !stable_q;
    xprev_d  = counterX;
    stable_d = same_x;

    if (!line_doubler) begin
      vis_h = 12'd480;
    end else if (is_pal && !add_line) begin
      vis_h = 12'd600;
    end else begin
      vis_h = 12'd504;
    end
    in_view = (counterX < LW) && (counterY < vis_h);

    row_base = (RING_LINES > 1)
             ? 12'(32'(counterY[SW-1:0]) * LINE_WIDTH)
             : 12'd0;

    // The sync pixel itself is captured, not just used as a trigger.
    enter = (state_q == SYNC_WAIT) && pix_ev && !resync &&
            (counterX == 12'd0) && (counterY == 12'd0);
    cap   = !resync && ((state_q == CAPTURE) || enter);

    line_start = cap && pix_ev && (counterX == 12'd0);
    full       = (pend_q == FULL);

    state_d = state_q;
    if (resync) begin
      state_d = SYNC_WAIT;
    end else if (enter) begin
      state_d = CAPTURE;
    end

    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (resync) begin
      drop_d = 1'b0;
      ovf_d  = 1'b0;
    end else if (line_start) begin
      drop_d = full;
      if (full) begin
        ovf_d = 1'b1;
      end
    end

    wr     = cap && pix_ev && in_view && !drop_d;
    wren_d = wr;
    addr_d = addr_q;
    data_d = data_q;
    if (wr) begin
      addr_d = row_base + counterX;
      data_d = {red, green, blue};
    end

    lr_d   = wr && (counterX == LAST_X);
    lnum_d = lr_d ? counterY : lnum_q;

    pend_d = pend_q;
    if (resync) begin
      pend_d = 3'd0;
    end else if (lr_q && !line_consumed) begin
      if (pend_q != FULL) begin
        pend_d = pend_q + 3'd1;
      end
    end else if (!lr_q && line_consumed) begin
      if (pend_q != 3'd0) begin
        pend_d = pend_q - 3'd1;
      end
    end
  end

  assign ram_wraddress = addr_q;
  assign ram_wrdata    = data_q;
  assign ram_wren      = wren_q;
  assign line_ready    = lr_q;
  assign line_number   = lnum_q;
  assign lines_pending = pend_q;
  assign overflow      = ovf_q;
  assign active        = (state_q == CAPTURE);

endmodule

// File: tb/tb_pixel_line_writer.sv
// Bench for pixel_line_writer: vector table, directed line
// sequences and random lines against a pixel-level model.
module tb_pixel_line_writer;

  localparam int LW = 720;
  localparam int RL = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        line_doubler;
  logic [7:0]  red, green, blue;
  logic [11:0] counterX, counterY;
  logic        add_line, is_pal, resync, line_consumed;
  logic [11:0] ram_wraddress;
  logic [23:0] ram_wrdata;
  logic        ram_wren, line_ready;
  logic [11:0] line_number;
  logic [2:0]  lines_pending;
  logic        overflow, active;

  always #5 clock = ~clock;

  pixel_line_writer #(.LINE_WIDTH(LW), .RING_LINES(RL)) dut (
    .clock(clock), .reset(reset), .line_doubler(line_doubler),
    .red(red), .green(green), .blue(blue),
    .counterX(counterX), .counterY(counterY),
    .add_line(add_line), .is_pal(is_pal), .resync(resync),
    .line_consumed(line_consumed),
    .ram_wraddress(ram_wraddress), .ram_wrdata(ram_wrdata),
    .ram_wren(ram_wren), .line_ready(line_ready),
    .line_number(line_number), .lines_pending(lines_pending),
    .overflow(overflow), .active(active)
  );

  int total = 0;
  int bad = 0;

  logic [35:0] got_wr[$];
  logic [35:0] exp_wr[$];
  logic [11:0] got_lr[$];
  logic [11:0] exp_lr[$];

  bit m_cap, m_ovf, m_drop, m_prev_lr;
  int m_pend;

  logic [2:0]  mid_pend, mid0_pend;
  logic        mid_ovf, mid_act;
  int          last_nwr, last_nlr;
  logic [11:0] last_lrnum;
  logic [23:0] base_col;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] rgb;
    logic        dbl, pal, addl;
    logic        ewren;
    logic [11:0] eaddr;
    logic [23:0] edata;
  } vec_t;

  vec_t tbl[12];

  always @(negedge clock) begin
    if (ram_wren) got_wr.push_back({ram_wraddress, ram_wrdata});
    if (line_ready) got_lr.push_back(line_number);
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cap = 0; m_ovf = 0; m_drop = 0; m_prev_lr = 0; m_pend = 0;
    got_wr.delete(); exp_wr.delete();
    got_lr.delete(); exp_lr.delete();
  endtask

  // Pending-count bookkeeping seen at the first clock of a pixel.
  task automatic model_start(input bit rs, input bit cn);
    if (rs) begin
      m_cap = 0; m_pend = 0; m_ovf = 0; m_drop = 0; m_prev_lr = 0;
    end else begin
      if (m_prev_lr && !cn) begin
        if (m_pend < RL) m_pend++;
      end else if (!m_prev_lr && cn && m_pend > 0) begin
        m_pend--;
      end
      m_prev_lr = 0;
    end
  endtask

  task automatic model_event(input int x, input int y,
                             input logic [23:0] c, input bit rs);
    int h;
    int addr;
    if (rs) return;
    h = !line_doubler ? 480 : (is_pal && !add_line) ? 600 : 504;
    if (!m_cap && x == 0 && y == 0) m_cap = 1;
    if (!m_cap) return;
    if (x == 0) begin
      m_drop = (m_pend == RL);
      if (m_drop) m_ovf = 1;
    end
    if (m_drop || x >= LW || y >= h) return;
    addr = (y % RL) * LW + x;
    exp_wr.push_back({addr[11:0], c});
    if (x == LW - 1) begin
      exp_lr.push_back(y[11:0]);
      m_prev_lr = 1;
    end
  endtask

  task automatic model_settle();
    if (m_prev_lr) begin
      if (m_pend < RL) m_pend++;
      m_prev_lr = 0;
    end
  endtask

  // One pixel: X/Y/colour held for two clocks, consume in the first.
  task automatic step(input int x, input int y, input logic [23:0] c,
                      input bit rs, input bit cn);
    counterX = x[11:0];
    counterY = y[11:0];
    {red, green, blue} = c;
    resync = rs;
    line_consumed = cn;
    @(posedge clock); #1;
    mid_pend = lines_pending;
    mid_ovf = overflow;
    mid_act = active;
    line_consumed = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic mstep(input int x, input int y, input logic [23:0] c,
                       input bit rs, input bit cn, input bit dc);
    model_start(rs, cn);
    step(x, y, c, rs, cn);
    if (dc) begin
      chk($sformatf("pending_y%0d_x%0d", y, x), 32'(mid_pend), m_pend);
      chk($sformatf("overflow_y%0d_x%0d", y, x), 32'(mid_ovf), 32'(m_ovf));
      chk($sformatf("active_y%0d_x%0d", y, x), 32'(mid_act), 32'(m_cap));
    end
    model_event(x, y, c, rs);
  endtask

  task automatic run_line(input int y, input int cons_x, input int rs_lo,
                          input int rs_hi, input bit rnd);
    logic [23:0] c;
    bit rs, dc;
    for (int x = 0; x < LW; x++) begin
      c = rnd ? 24'($urandom) : base_col;
      rs = (x >= rs_lo) && (x <= rs_hi);
      dc = (x == 0) || (x == 1) || (x == 300) || (x == LW - 1);
      mstep(x, y, c, rs, (x == cons_x), dc);
      if (x == 0) mid0_pend = mid_pend;
    end
  endtask

  task automatic flush(input string tag);
    int mism;
    @(posedge clock); #1;
    model_settle();
    last_nwr = got_wr.size();
    last_nlr = got_lr.size();
    last_lrnum = (got_lr.size() > 0) ? got_lr[0] : 12'hFFF;
    chk({tag, "_nwr"}, got_wr.size(), exp_wr.size());
    mism = 0;
    for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
      if (got_wr[i] !== exp_wr[i]) mism++;
    chk({tag, "_wr_mismatches"}, mism, 0);
    chk({tag, "_nlr"}, got_lr.size(), exp_lr.size());
    mism = 0;
    for (int i = 0; i < got_lr.size() && i < exp_lr.size(); i++)
      if (got_lr[i] !== exp_lr[i]) mism++;
    chk({tag, "_lr_mismatches"}, mism, 0);
    chk({tag, "_pending"}, 32'(lines_pending), m_pend);
    chk({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, "_active"}, 32'(active), 32'(m_cap));
    got_wr.delete(); exp_wr.delete();
    got_lr.delete(); exp_lr.delete();
  endtask

  task automatic consume_pulse();
    line_consumed = 1'b1;
    @(posedge clock); #1;
    line_consumed = 1'b0;
    model_settle();
    if (m_pend > 0) m_pend--;
    chk("consume_pending", 32'(lines_pending), m_pend);
  endtask

  task automatic apply_reset(input bit do_chk, input string tag);
    reset = 1'b1;
    repeat (3) begin
      {red, green, blue} = 24'($urandom);
      counterX = 12'($urandom);
      counterY = 12'($urandom);
      {line_doubler, add_line, is_pal} = 3'($urandom);
      {resync, line_consumed} = 2'($urandom);
      @(posedge clock); #1;
    end
    if (do_chk) begin
      chk({tag, "_wraddress"}, 32'(ram_wraddress), 0);
      chk({tag, "_wrdata"}, 32'(ram_wrdata), 0);
      chk({tag, "_wren"}, 32'(ram_wren), 0);
      chk({tag, "_line_ready"}, 32'(line_ready), 0);
      chk({tag, "_line_number"}, 32'(line_number), 0);
      chk({tag, "_pending"}, 32'(lines_pending), 0);
      chk({tag, "_overflow"}, 32'(overflow), 0);
      chk({tag, "_active"}, 32'(active), 0);
    end
    reset = 1'b0;
    resync = 1'b0;
    line_consumed = 1'b0;
    line_doubler = 1'b0;
    is_pal = 1'b0;
    add_line = 1'b0;
    model_reset();
  endtask

  initial begin
    tbl[0]  = '{3,   5,   24'h123456, 0, 0, 0, 1, 12'd723,  24'h123456};
    tbl[1]  = '{719, 3,   24'hABCDEF, 0, 0, 0, 1, 12'd2879, 24'hABCDEF};
    tbl[2]  = '{10,  480, 24'h111111, 0, 0, 0, 0, 12'd2879, 24'hABCDEF};
    tbl[3]  = '{11,  480, 24'h222222, 1, 0, 0, 1, 12'd11,   24'h222222};
    tbl[4]  = '{720, 503, 24'h333333, 1, 0, 0, 0, 12'd11,   24'h222222};
    tbl[5]  = '{1,   504, 24'h444444, 1, 0, 0, 0, 12'd11,   24'h222222};
    tbl[6]  = '{2,   599, 24'h555555, 1, 1, 0, 1, 12'd2162, 24'h555555};
    tbl[7]  = '{4,   599, 24'h666666, 1, 1, 1, 0, 12'd2162, 24'h555555};
    tbl[8]  = '{5,   600, 24'h777777, 1, 1, 0, 0, 12'd2162, 24'h555555};
    tbl[9]  = '{100, 7,   24'h888888, 0, 0, 0, 1, 12'd2260, 24'h888888};
    tbl[10] = '{6,   503, 24'h999999, 1, 0, 0, 1, 12'd2166, 24'h999999};
    tbl[11] = '{8,   479, 24'hAAAAAA, 0, 0, 0, 1, 12'd2168, 24'hAAAAAA};

    reset = 1'b1;
    resync = 1'b0;
    line_consumed = 1'b0;
    @(posedge clock); #1;
    apply_reset(1, "reset1");

    // Full first line from reset.
    base_col = 24'($urandom);
    run_line(0, -1, -1, -1, 0);
    flush("line0");
    chk("full_line_nwr", last_nwr, 720);
    chk("full_line_nlr", last_nlr, 1);
    chk("full_line_number", 32'(last_lrnum), 0);
    chk("full_line_pending", 32'(lines_pending), 1);

    // Fill the ring, then one line too many.
    for (int y = 1; y < 4; y++) begin
      run_line(y, -1, -1, -1, 0);
      flush($sformatf("fill%0d", y));
    end
    chk("ring_full_pending", 32'(lines_pending), 4);
    run_line(4, -1, -1, -1, 0);
    flush("ovf_line");
    chk("ovf_line_nwr", last_nwr, 0);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_pending", 32'(lines_pending), 4);

    // Lose sync mid-line; capture only resumes at (0,0).
    run_line(5, 0, 300, 305, 1);
    flush("resync_line");
    chk("resync_nwr", last_nwr, 300);
    chk("resync_nlr", last_nlr, 0);
    chk("resync_active", 32'(active), 0);
    chk("resync_pending", 32'(lines_pending), 0);
    chk("resync_overflow", 32'(overflow), 0);
    run_line(6, -1, -1, -1, 1);
    flush("after_resync");
    chk("after_resync_nwr", last_nwr, 0);
    run_line(0, -1, -1, -1, 1);
    flush("resume");
    chk("resume_nwr", last_nwr, 720);
    chk("resume_active", 32'(active), 1);

    apply_reset(1, "reset2");

    // Single-pixel address/data vectors inside CAPTURE.
    step(0, 0, 24'h010203, 0, 0);
    chk("enter_wren", 32'(ram_wren), 1);
    chk("enter_addr", 32'(ram_wraddress), 0);
    for (int i = 0; i < 12; i++) begin
      line_doubler = tbl[i].dbl;
      is_pal = tbl[i].pal;
      add_line = tbl[i].addl;
      step(tbl[i].x, tbl[i].y, tbl[i].rgb, 0, 0);
      chk($sformatf("vec%0d_wren", i), 32'(ram_wren), 32'(tbl[i].ewren));
      chk($sformatf("vec%0d_addr", i), 32'(ram_wraddress),
          32'(tbl[i].eaddr));
      chk($sformatf("vec%0d_data", i), 32'(ram_wrdata), 32'(tbl[i].edata));
      if (i == 1) begin
        chk("vec1_line_ready", 32'(line_ready), 1);
        chk("vec1_line_number", 32'(line_number), 3);
      end
    end

    // Simultaneous ready/consume, and consume when empty.
    apply_reset(0, "reset3");
    base_col = 24'h0F0F0F;
    run_line(0, -1, -1, -1, 0);
    flush("cons0");
    run_line(1, -1, -1, -1, 0);
    flush("cons1");
    chk("cons_pending2", 32'(lines_pending), 2);
    run_line(2, -1, -1, -1, 0);
    run_line(3, 0, -1, -1, 0);
    chk("same_clock_pending", 32'(mid0_pend), 2);
    flush("cons3");
    repeat (3) consume_pulse();
    chk("drained_pending", 32'(lines_pending), 0);
    consume_pulse();
    chk("empty_consume_pending", 32'(lines_pending), 0);

    // Reset sampled on the event edge of the last pixel of a line.
    apply_reset(0, "reset4");
    mstep(0, 0, 24'h5A5A5A, 0, 0, 0);
    counterX = 12'd719;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_mid_wren", 32'(ram_wren), 0);
    chk("rst_mid_line_ready", 32'(line_ready), 0);
    chk("rst_mid_active", 32'(active), 0);
    chk("rst_mid_wrdata", 32'(ram_wrdata), 0);
    chk("rst_mid_nwr", got_wr.size(), 1);
    chk("rst_mid_nlr", got_lr.size(), 0);

    // Random lines against the model.
    apply_reset(0, "reset5");
    for (int n = 0; n < 12; n++) begin
      int y, cx, lo, hi;
      {line_doubler, is_pal, add_line} = 3'($urandom);
      case ($urandom % 4)
        0: y = 0;
        1: y = $urandom % 8;
        2: y = 476 + ($urandom % 8);
        default: y = (($urandom % 2) != 0) ? 500 + ($urandom % 8)
                                           : 596 + ($urandom % 8);
      endcase
      cx = (($urandom % 3) == 0) ? int'($urandom % LW) : -1;
      lo = -1;
      hi = -1;
      if (($urandom % 4) == 0) begin
        lo = $urandom % LW;
        hi = lo + ($urandom % 5);
      end
      run_line(y, cx, lo, hi, 1);
      if (($urandom % 2) != 0 || n == 11) flush($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
